// File: rtl/alu_pkg.sv
// Shared types for the ALU-sharing arbiter: ALU opcodes, FSM states,
// and the saturating completion-counter helper.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam int OPS_W = 16;

    function automatic logic [OPS_W-1:0] sat_inc(input logic [OPS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found scanning upward from ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [N-1:0]   rot;
    logic [N-1:0]   rot_grant;
    logic [2*N-1:0] grant_dbl;

    // Rotate so ptr sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rot_grant = '0;
        rot       = N'({req, req} >> ptr);
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) rot_grant = N'(1) << k;
        end
        grant_dbl = {{N{1'b0}}, rot_grant} << ptr;
        grant     = grant_dbl[N-1:0] | grant_dbl[2*N-1:N];
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU among NUM_REQ requesters: round-robin accept,
// one execute cycle, then an id-tagged response held until consumed.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*2-1:0]       req_op,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [1:0]                 alu_control,
    input  logic [WIDTH-1:0]           alu_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [WIDTH-1:0]           rsp_result,
    output logic [OPS_W-1:0]           ops_done
);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr, ptr_nxt, sel_id;
    logic [NUM_REQ-1:0] grant;
    logic [WIDTH-1:0]  sel_a, sel_b;
    logic [1:0]        sel_op;
    logic              accept;
    alu_op_t           op_q;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        sel_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_op = req_op[i*2 +: 2];
                sel_id = ID_W'(i);
            end
        end
    end

    assign ptr_nxt     = (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
    assign alu_control = op_q;

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = grant;
                accept    = |req_valid;
                if (accept) state_nxt = EXEC;
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            op_q       <= ADD;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_valid  <= 1'b0;
            ops_done   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_a  <= sel_a;
                alu_b  <= sel_b;
                op_q   <= alu_op_t'(sel_op);
                rsp_id <= sel_id;
                ptr    <= ptr_nxt;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_valid  <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                ops_done  <= sat_inc(ops_done);
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter with a behavioural ALU and a transaction-level
// reference model compared every cycle, plus directed literal checks.
module tb_alu_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*2-1:0]     req_op;
    logic [WIDTH-1:0]         alu_a, alu_b, alu_result;
    logic [1:0]               alu_control;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [1:0]               rsp_id;
    logic [WIDTH-1:0]         rsp_result;
    logic [15:0]              ops_done;

    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];
    logic [1:0]       op_arr[NUM_REQ];

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .ops_done    (ops_done)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = a_arr[i];
            req_b[i*WIDTH +: WIDTH] = b_arr[i];
            req_op[i*2 +: 2]        = op_arr[i];
        end
    end

    // Bench-side ALU instance.
    always_comb begin
        case (alu_control)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a + ~alu_b + 32'd1;
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic int winner(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    int          m_stage = 0;   // 0 waiting for request, 1 executing, 2 holding response
    int          m_ptr = 0, m_id = 0, m_ops = 0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic [1:0]  m_op = '0;
    bit          m_rv = 1'b0;

    always @(posedge clk or posedge reset) begin
        int g;
        if (reset) begin
            m_stage = 0; m_ptr = 0; m_id = 0; m_ops = 0;
            m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_rv = 1'b0;
        end else begin
            case (m_stage)
                0: begin
                    g = winner(req_valid, m_ptr);
                    if (g >= 0) begin
                        m_a = a_arr[g]; m_b = b_arr[g]; m_op = op_arr[g];
                        m_id = g; m_ptr = (g + 1) % NUM_REQ; m_stage = 1;
                    end
                end
                1: begin
                    m_res = model_alu(m_op, m_a, m_b); m_rv = 1'b1; m_stage = 2;
                end
                default: begin
                    if (rsp_ready) begin
                        m_rv = 1'b0; m_stage = 0;
                        m_ops = (m_ops >= 65535) ? 65535 : m_ops + 1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        int g;
        logic [NUM_REQ-1:0] er;
        if (cmp_en) begin
            g  = winner(req_valid, m_ptr);
            er = '0;
            if (m_stage == 0 && g >= 0) er[g] = 1'b1;
            check("m_req_ready",   32'(req_ready),   32'(er));
            check("m_rsp_valid",   32'(rsp_valid),   32'(m_rv));
            check("m_rsp_id",      32'(rsp_id),      32'(m_id));
            check("m_rsp_result",  rsp_result,       m_res);
            check("m_alu_a",       alu_a,            m_a);
            check("m_alu_b",       alu_b,            m_b);
            check("m_alu_control", 32'(alu_control), 32'(m_op));
            check("m_ops_done",    32'(ops_done),    32'(m_ops));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        a_arr[idx] = a; b_arr[idx] = b; op_arr[idx] = op;
    endtask

    // Full transaction with rsp_ready high; returns at IDLE after the response is consumed.
    task automatic issue(input int idx, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [1:0] id, output logic [31:0] res);
        int  n;
        bit  got;
        set_req(idx, op, a, b);
        req_valid[idx] = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            got = req_ready[idx];
            step();
            n++;
        end
        req_valid[idx] = 1'b0;
        if (!got) check("issue_grant_timeout", 0, 1);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check("issue_rsp_timeout", 0, 1);
        id  = rsp_id;
        res = rsp_result;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  id;
        logic [31:0] res;
        int g_idx[8], g_cyc[8], g_cnt;

        reset = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'd0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_ops_done", 32'(ops_done), 0);
        step();
        reset = 1'b0;
        step();

        // Req0 ADD 5+7, cycle-accurate latency
        set_req(0, 2'd0, 32'd5, 32'd7);
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("t1_ready0", 32'(req_ready), 32'b0001);
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("t1_exec_no_rsp", 32'(rsp_valid), 0);
        step();
        @(negedge clk);
        check("t1_rsp_valid", 32'(rsp_valid), 1);
        check("t1_rsp_id", 32'(rsp_id), 0);
        check("t1_rsp_result", rsp_result, 32'd12);
        step();

        issue(1, 2'd1, 32'd0, 32'd1, id, res);
        check("t2_sub_id", 32'(id), 1);
        check("t2_sub_wrap", res, 32'hFFFF_FFFF);
        issue(2, 2'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, id, res);
        check("t2_and_id", 32'(id), 2);
        check("t2_and", res, 32'hF000_F000);

        // All requesters valid: strict rotation from pointer 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'(i), 32'(i * 10 + 1), 32'(i));
        for (int k = 0; k < 8; k++) begin g_idx[k] = -1; g_cyc[k] = -1; end
        g_cnt = 0;
        req_valid = 4'hF;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (req_ready != '0 && g_cnt < 8) begin
                for (int j = 0; j < NUM_REQ; j++) if (req_ready[j]) g_idx[g_cnt] = j;
                g_cyc[g_cnt] = c;
                g_cnt++;
            end
            step();
        end
        req_valid = '0;
        @(negedge clk);
        check("t3_grant_count", g_cnt, 5);
        for (int k = 0; k < 5; k++) begin
            check("t3_grant_order", g_idx[k], k % NUM_REQ);
            check("t3_grant_cycle", g_cyc[k], 3 * k);
        end
        check("t3_ops_done", 32'(ops_done), 5);
        step();

        // Back-pressure: pointer is 1, req2 OR then req0 waits
        rsp_ready = 1'b0;
        set_req(2, 2'd3, 32'h1234_0000, 32'h0000_5678);
        set_req(0, 2'd0, 32'hFFFF_FFFF, 32'd1);
        req_valid[2] = 1'b1;
        @(negedge clk);
        check("t4_ready2", 32'(req_ready), 32'b0100);
        step();
        req_valid[2] = 1'b0;
        req_valid[0] = 1'b1;
        step();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(rsp_valid), 1);
            check("t4_hold_id", 32'(rsp_id), 2);
            check("t4_hold_result", rsp_result, 32'h1234_5678);
            check("t4_hold_noready", 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        @(negedge clk);
        check("t4_after_ready0", 32'(req_ready), 32'b0001);
        step();
        req_valid[0] = 1'b0;
        step();
        @(negedge clk);
        check("t4_add_wrap", rsp_result, 32'd0);
        step();

        // Reset while executing: pointer is 1 here
        set_req(1, 2'd1, 32'd10, 32'd3);
        req_valid[1] = 1'b1;
        @(negedge clk);
        check("t5_ready1", 32'(req_ready), 32'b0010);
        step();
        req_valid[1] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("t5_reset_rsp", 32'(rsp_valid), 0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t5_no_stale", 32'(rsp_valid), 0);
            step();
        end
        set_req(3, 2'd0, 32'd100, 32'd23);
        set_req(0, 2'd2, 32'hFF, 32'h0F);
        req_valid = 4'b1001;
        @(negedge clk);
        check("t5_ptr_zero", 32'(req_ready), 32'b0001);
        step();
        req_valid[0] = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("t5_ready3", 32'(req_ready), 32'b1000);
        step();
        req_valid[3] = 1'b0;
        step();
        @(negedge clk);
        check("t5_rsp3_id", 32'(rsp_id), 3);
        check("t5_rsp3_result", rsp_result, 32'd123);
        step();

        // Saturating completion counter
        force dut.ops_done = 16'hFFFF;
        m_ops = 65535;
        step();
        release dut.ops_done;
        @(negedge clk);
        check("t6_preload", 32'(ops_done), 32'hFFFF);
        issue(2, 2'd0, 32'd1, 32'd2, id, res);
        @(negedge clk);
        check("t6_result", res, 32'd3);
        check("t6_saturate", 32'(ops_done), 32'hFFFF);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
